midi_voice_allocator: RTL and testbench
=======================================

// Module: midi_voice_allocator
// PURPOSE
//  Consumes decoded 3-byte MIDI messages from the MIDI byte parser and keeps a polyphonic voice table.
//  Note-on allocates a voice, note-off releases it, and CC64 (sustain) and CC123 (all notes off) are honoured.
//  Per-voice note, velocity, gate and trigger outputs drive the synth voice generators downstream.
// PARAMETERS
//  NUM_VOICES  4  number of voice slots (2..8); voice index 0 is the lowest
// PORTS
//  clk_in            input   1               system clock
//  rst_in            input   1               synchronous, active-high reset
//  status_in         input   4               [2:0] = MIDI status[6:4]; [3] ignored
//  data_byte1_in     input   8               note or CC number; bit 7 ignored
//  data_byte2_in     input   8               velocity or CC value; bit 7 ignored
//  valid_in          input   1               level; a rising edge marks one new complete message
//  voice_active_out  output  NUM_VOICES      voice sounding (gated or sustained)
//  voice_gate_out    output  NUM_VOICES      key physically held
//  voice_trig_out    output  NUM_VOICES      1-cycle pulse on (re)allocation
//  voice_note_out    output  7*NUM_VOICES    voice v note = [7v+6:7v]
//  voice_vel_out     output  7*NUM_VOICES    voice v velocity = [7v+6:7v]
//  sustain_out       output  1               sustain pedal state
// BEHAVIOUR
//  - Reset: every output is 0, the internal valid_d register is 0, and the LRU ages are v (voice v has age v).
//    Reset has priority over any message in the same cycle.
//  - Message detect: a message is new when valid_in=1 and valid_d=0; valid_d <= valid_in every cycle.
//    The inputs are sampled in that cycle. Holding valid_in high never reprocesses a message.
//  - Latency: table outputs update on the clock edge after the detect cycle; voice_trig_out is high for exactly that one cycle.
//  - Message decode (n = data_byte1_in[6:0], k = data_byte2_in[6:0]):
//    - status[2:0]=3'd1 with k!=0: NOTE_ON.
//    - status[2:0]=3'd0, or 3'd1 with k==0: NOTE_OFF.
//    - status[2:0]=3'd3 with n=64: SUSTAIN; sustain_out <= (k>=64).
//    - status[2:0]=3'd3 with n=123: ALL_OFF.
//    - Anything else is ignored and causes no output change.
//  - NOTE_ON voice selection, first match wins:
//    1. A voice is active with note==n: retrigger that voice.
//    2. Otherwise, the lowest-index inactive voice.
//    3. Otherwise, steal the voice with the maximum age.
//    The chosen voice gets note=n, vel=k, active=1, gate=1 and trig=1.
//  - LRU update on a NOTE_ON to voice c with old age a: age[c] <= 0, and every voice with age < a gets age+1.
//    The ages always stay a permutation of 0..NUM_VOICES-1.
//  - NOTE_OFF: for the voice(s) with active=1 and note==n, gate <= 0.
//    - With sustain_out=0, active <= 0 as well.
//    - With sustain_out=1, active stays 1 (sustained).
//    - If no voice matches, nothing changes.
//    - Note and velocity fields are retained after release.
//  - SUSTAIN falling (1->0): every voice with active=1 and gate=0 gets active <= 0 in the same update.
//    A rising edge, or a repeat of the current value, changes no voice.
//  - ALL_OFF: all gate and active bits go to 0; sustain_out is unchanged; the LRU is unchanged.
//  - NOTE_ON on a sustained voice (active=1, gate=0) with matching note retriggers it and sets gate=1.
//  - At most one message is processed per cycle; no back-pressure exists (MIDI rate is far below clk_in).
//  - Mid-operation reset: all voices are silenced at once and the next message after reset is decoded normally.
// TESTING
//  - Note on after reset: NOTE_ON n=60 k=100 -> next cycle voice 0: active=1, gate=1, note=60, vel=100;
//    trig=4'b0001 for 1 cycle.
//  - Voice stealing: NOTE_ON 60,62,64,65 then 67 (k=90) -> 67 lands in voice 0 (the oldest), trig[0] pulses,
//    and voices 1..3 are unchanged.
//  - Retrigger and off: NOTE_ON 60 k=100 then NOTE_ON 60 k=20 -> same voice, vel=20, trig pulses again.
//    Then status=1 n=60 k=0 -> active=0, gate=0.
//  - Sustain: CC64 k=127, NOTE_ON 60, NOTE_OFF 60 -> gate=0, active=1.
//    Then CC64 k=0 -> active=0 on the next edge.
//  - Level handling and all-off: hold valid_in high 20 cycles after one NOTE_ON -> exactly one trig pulse.
//    Then CC123 -> all active and gate bits are 0.
//  - Reset mid-stream: rst_in for 1 cycle while 3 voices are active -> all outputs 0;
//    the next NOTE_ON allocates voice 0.

Source files
------------

// File: rtl/midi_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : midi_voice_allocator
//  Purpose  : Polyphonic voice table driven by decoded 3-byte MIDI messages.
//             Note-on allocates (retrigger / free voice / LRU steal), note-off
//             releases, CC64 sustain holds released voices, CC123 silences all.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_in            in   1             system clock
//    rst_in            in   1             synchronous active-high reset
//    status_in         in   4             [2:0] = MIDI status[6:4]
//    data_byte1_in     in   8             note / CC number ([6:0] used)
//    data_byte2_in     in   8             velocity / CC value ([6:0] used)
//    valid_in          in   1             level; rising edge = new message
//    voice_active_out  out  NUM_VOICES    voice sounding (gated or sustained)
//    voice_gate_out    out  NUM_VOICES    key physically held
//    voice_trig_out    out  NUM_VOICES    1-cycle pulse on (re)allocation
//    voice_note_out    out  7*NUM_VOICES  voice v note at [7v+6:7v]
//    voice_vel_out     out  7*NUM_VOICES  voice v velocity at [7v+6:7v]
//    sustain_out       out  1             sustain pedal state
// ============================================================================
module midi_voice_allocator #(
    parameter int NUM_VOICES = 4
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [3:0]                status_in,
    input  logic [7:0]                data_byte1_in,
    input  logic [7:0]                data_byte2_in,
    input  logic                      valid_in,
    output logic [NUM_VOICES-1:0]     voice_active_out,
    output logic [NUM_VOICES-1:0]     voice_gate_out,
    output logic [NUM_VOICES-1:0]     voice_trig_out,
    output logic [7*NUM_VOICES-1:0]   voice_note_out,
    output logic [7*NUM_VOICES-1:0]   voice_vel_out,
    output logic                      sustain_out
);

    localparam int            AW          = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AW-1:0] c_AGE_MAX   = AW'(NUM_VOICES - 1);
    localparam logic [AW-1:0] c_AGE_ONE   = AW'(1);
    localparam logic [2:0]    c_ST_OFF    = 3'd0;
    localparam logic [2:0]    c_ST_ON     = 3'd1;
    localparam logic [2:0]    c_ST_CC     = 3'd3;
    localparam logic [6:0]    c_CC_SUS    = 7'd64;
    localparam logic [6:0]    c_CC_ALLOFF = 7'd123;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                  valid_d_q;
    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [NUM_VOICES-1:0] gate_q,   gate_d;
    logic [NUM_VOICES-1:0] trig_q,   trig_d;
    logic [6:0]            note_q [NUM_VOICES];
    logic [6:0]            note_d [NUM_VOICES];
    logic [6:0]            vel_q  [NUM_VOICES];
    logic [6:0]            vel_d  [NUM_VOICES];
    logic [AW-1:0]         age_q  [NUM_VOICES];
    logic [AW-1:0]         age_d  [NUM_VOICES];
    logic                  sustain_q, sustain_d;

    // ------------------------------------------------------------------------
    // Message detect and decode
    // ------------------------------------------------------------------------
    logic       w_new;
    logic [2:0] w_st;
    logic [6:0] w_n;
    logic [6:0] w_k;
    logic       w_note_on;
    logic       w_note_off;
    logic       w_sus_msg;
    logic       w_all_off;
    logic       w_sus_val;
    logic       w_unused_bits;

    assign w_new      = valid_in & ~valid_d_q;
    assign w_st       = status_in[2:0];
    assign w_n        = data_byte1_in[6:0];
    assign w_k        = data_byte2_in[6:0];
    assign w_note_on  = w_new && (w_st == c_ST_ON) && (w_k != 7'd0);
    assign w_note_off = w_new && ((w_st == c_ST_OFF) || ((w_st == c_ST_ON) && (w_k == 7'd0)));
    assign w_sus_msg  = w_new && (w_st == c_ST_CC) && (w_n == c_CC_SUS);
    assign w_all_off  = w_new && (w_st == c_ST_CC) && (w_n == c_CC_ALLOFF);
    assign w_sus_val  = w_k[6];   // k >= 64

    // Bits carried by the MIDI framing that carry no meaning here.
    assign w_unused_bits = ^{status_in[3], data_byte1_in[7], data_byte2_in[7]};

    // Voices currently sounding the incoming note number.
    logic [NUM_VOICES-1:0] w_match;

    generate
        for (genvar v = 0; v < NUM_VOICES; v++) begin : g_match
            assign w_match[v] = active_q[v] && (note_q[v] == w_n);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Note-on voice selection: existing note, else lowest free, else oldest.
    // Ages are a permutation, so exactly one voice holds the maximum age.
    // ------------------------------------------------------------------------
    logic [AW-1:0] w_sel;
    logic          w_found;

    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!w_found && w_match[i]) begin
                w_sel   = AW'(i);
                w_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!w_found && !active_q[i]) begin
                w_sel   = AW'(i);
                w_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!w_found && (age_q[i] == c_AGE_MAX)) begin
                w_sel   = AW'(i);
                w_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state table update
    // ------------------------------------------------------------------------
    always_comb begin
        active_d  = active_q;
        gate_d    = gate_q;
        trig_d    = '0;
        note_d    = note_q;
        vel_d     = vel_q;
        age_d     = age_q;
        sustain_d = sustain_q;

        if (w_note_on) begin
            active_d[w_sel] = 1'b1;
            gate_d[w_sel]   = 1'b1;
            trig_d[w_sel]   = 1'b1;
            note_d[w_sel]   = w_n;
            vel_d[w_sel]    = w_k;
            // Chosen voice becomes youngest; only voices younger than it age,
            // which keeps the ages a permutation.
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (AW'(i) == w_sel) begin
                    age_d[i] = '0;
                end else if (age_q[i] < age_q[w_sel]) begin
                    age_d[i] = age_q[i] + c_AGE_ONE;
                end
            end
        end else if (w_note_off) begin
            gate_d = gate_q & ~w_match;
            if (!sustain_q) begin
                active_d = active_q & ~w_match;
            end
        end else if (w_sus_msg) begin
            sustain_d = w_sus_val;
            // Pedal release drops every voice whose key is already up.
            if (sustain_q && !w_sus_val) begin
                active_d = active_q & gate_q;
            end
        end else if (w_all_off) begin
            active_d = '0;
            gate_d   = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_d_q <= 1'b0;
            active_q  <= '0;
            gate_q    <= '0;
            trig_q    <= '0;
            sustain_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= AW'(i);
            end
        end else begin
            valid_d_q <= valid_in;
            active_q  <= active_d;
            gate_q    <= gate_d;
            trig_q    <= trig_d;
            sustain_q <= sustain_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= note_d[i];
                vel_q[i]  <= vel_d[i];
                age_q[i]  <= age_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign voice_active_out = active_q;
    assign voice_gate_out   = gate_q;
    assign voice_trig_out   = trig_q;
    assign sustain_out      = sustain_q;

    generate
        for (genvar v = 0; v < NUM_VOICES; v++) begin : g_pack
            assign voice_note_out[7*v +: 7] = note_q[v];
            assign voice_vel_out[7*v +: 7]  = vel_q[v];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_midi_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_midi_voice_allocator
//  Purpose  : Self-checking bench for midi_voice_allocator. A behavioural
//             voice-table model (LRU kept as a recency-ordered queue) is
//             compared against the DUT every cycle, plus literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_midi_voice_allocator;

    localparam int N = 4;

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b1;
    logic [3:0]     status_in = '0;
    logic [7:0]     data_byte1_in = '0;
    logic [7:0]     data_byte2_in = '0;
    logic           valid_in = 1'b0;
    logic [N-1:0]   voice_active_out;
    logic [N-1:0]   voice_gate_out;
    logic [N-1:0]   voice_trig_out;
    logic [7*N-1:0] voice_note_out;
    logic [7*N-1:0] voice_vel_out;
    logic           sustain_out;

    midi_voice_allocator #(.NUM_VOICES(N)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .status_in        (status_in),
        .data_byte1_in    (data_byte1_in),
        .data_byte2_in    (data_byte2_in),
        .valid_in         (valid_in),
        .voice_active_out (voice_active_out),
        .voice_gate_out   (voice_gate_out),
        .voice_trig_out   (voice_trig_out),
        .voice_note_out   (voice_note_out),
        .voice_vel_out    (voice_vel_out),
        .sustain_out      (sustain_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model. lru holds voice indices, most recently allocated at
    // the front; the voice at the back is the one to steal.
    // ------------------------------------------------------------------------
    int m_note [N];
    int m_vel  [N];
    bit m_act  [N];
    bit m_gate [N];
    bit m_trig [N];
    bit m_sus;
    bit m_prev;
    int lru [$];

    task automatic model_reset();
        lru.delete();
        for (int v = 0; v < N; v++) begin
            m_note[v] = 0; m_vel[v] = 0; m_act[v] = 0; m_gate[v] = 0; m_trig[v] = 0;
            lru.push_back(v);
        end
        m_sus  = 0;
        m_prev = 0;
    endtask

    task automatic model_msg(input int st, input int n, input int k);
        int c;
        c = -1;
        if (st == 1 && k != 0) begin
            for (int v = 0; v < N; v++) if (c < 0 && m_act[v] && m_note[v] == n) c = v;
            for (int v = 0; v < N; v++) if (c < 0 && !m_act[v]) c = v;
            if (c < 0) c = lru[lru.size()-1];
            m_note[c] = n; m_vel[c] = k; m_act[c] = 1; m_gate[c] = 1; m_trig[c] = 1;
            for (int i = 0; i < lru.size(); i++) begin
                if (lru[i] == c) begin
                    lru.delete(i);
                    break;
                end
            end
            lru.push_front(c);
        end else if (st == 0 || st == 1) begin
            for (int v = 0; v < N; v++) begin
                if (m_act[v] && m_note[v] == n) begin
                    m_gate[v] = 0;
                    if (!m_sus) m_act[v] = 0;
                end
            end
        end else if (st == 3 && n == 64) begin
            if (m_sus && k < 64)
                for (int v = 0; v < N; v++) if (!m_gate[v]) m_act[v] = 0;
            m_sus = (k >= 64);
        end else if (st == 3 && n == 123) begin
            for (int v = 0; v < N; v++) begin
                m_act[v] = 0; m_gate[v] = 0;
            end
        end
    endtask

    always @(posedge clk_in) begin
        if (rst_in) begin
            model_reset();
        end else begin
            for (int v = 0; v < N; v++) m_trig[v] = 0;
            if (valid_in && !m_prev)
                model_msg(int'(status_in[2:0]), int'(data_byte1_in[6:0]), int'(data_byte2_in[6:0]));
            m_prev = valid_in;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_in) begin
        logic [N-1:0]   e_act, e_gate, e_trig;
        logic [7*N-1:0] e_note, e_vel;
        if (check_en) begin
            for (int v = 0; v < N; v++) begin
                e_act[v]        = m_act[v];
                e_gate[v]       = m_gate[v];
                e_trig[v]       = m_trig[v];
                e_note[7*v +: 7] = 7'(m_note[v]);
                e_vel[7*v +: 7]  = 7'(m_vel[v]);
            end
            check("model_active", 64'(voice_active_out), 64'(e_act));
            check("model_gate",   64'(voice_gate_out),   64'(e_gate));
            check("model_trig",   64'(voice_trig_out),   64'(e_trig));
            check("model_note",   64'(voice_note_out),   64'(e_note));
            check("model_vel",    64'(voice_vel_out),    64'(e_vel));
            check("model_sus",    64'(sustain_out),      64'(m_sus));
        end
    end

    // One-cycle valid pulse; returns on the negedge just after the update edge.
    task automatic send(input logic [3:0] st, input logic [7:0] b1, input logic [7:0] b2);
        @(negedge clk_in);
        status_in     = st;
        data_byte1_in = b1;
        data_byte2_in = b2;
        valid_in      = 1'b1;
        @(negedge clk_in);
        valid_in      = 1'b0;
    endtask

    initial begin
        int trig_cnt;

        // Reset state
        rst_in = 1'b1;
        @(negedge clk_in);
        check_en = 1'b1;
        repeat (2) @(negedge clk_in);
        check("rst_active", 64'(voice_active_out), 64'h0);
        check("rst_note",   64'(voice_note_out),   64'h0);
        check("rst_sus",    64'(sustain_out),      64'h0);
        rst_in = 1'b0;

        // Note on after reset
        send(4'h1, 8'd60, 8'd100);
        check("on_active", 64'(voice_active_out),      64'b0001);
        check("on_gate",   64'(voice_gate_out),        64'b0001);
        check("on_trig",   64'(voice_trig_out),        64'b0001);
        check("on_note0",  64'(voice_note_out[6:0]),   64'd60);
        check("on_vel0",   64'(voice_vel_out[6:0]),    64'd100);
        @(negedge clk_in);
        check("on_trig_end", 64'(voice_trig_out), 64'h0);

        // Fill all voices, then steal the oldest (voice 0)
        send(4'h1, 8'd62, 8'd70);
        send(4'h1, 8'd64, 8'd71);
        send(4'h1, 8'd65, 8'd72);
        send(4'h1, 8'd67, 8'd90);
        check("steal_trig",  64'(voice_trig_out),       64'b0001);
        check("steal_note0", 64'(voice_note_out[6:0]),  64'd67);
        check("steal_vel0",  64'(voice_vel_out[6:0]),   64'd90);
        check("steal_notes", 64'(voice_note_out[27:7]), 64'({7'd65, 7'd64, 7'd62}));

        // Retrigger same note, then note-off via velocity 0
        send(4'h1, 8'd67, 8'd20);
        check("retrig_trig", 64'(voice_trig_out),     64'b0001);
        check("retrig_vel",  64'(voice_vel_out[6:0]), 64'd20);
        send(4'h1, 8'd67, 8'd0);
        check("off_active", 64'(voice_active_out), 64'b1110);
        check("off_gate",   64'(voice_gate_out),   64'b1110);
        check("off_note_kept", 64'(voice_note_out[6:0]), 64'd67);

        // Sustain hold and pedal release
        send(4'h3, 8'd64, 8'd127);
        send(4'h1, 8'd60, 8'd50);
        send(4'h0, 8'd60, 8'd0);
        check("sus_active", 64'(voice_active_out), 64'b1111);
        check("sus_gate",   64'(voice_gate_out),   64'b1110);
        check("sus_on",     64'(sustain_out),      64'h1);
        send(4'h3, 8'd64, 8'd127);   // repeat: no voice change
        check("sus_repeat", 64'(voice_active_out), 64'b1111);
        send(4'h3, 8'd64, 8'd0);
        check("sus_release", 64'(voice_active_out), 64'b1110);

        // Held valid level: exactly one message processed
        @(negedge clk_in);
        status_in = 4'h1; data_byte1_in = 8'd70; data_byte2_in = 8'd33; valid_in = 1'b1;
        trig_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (voice_trig_out != '0) trig_cnt++;
        end
        valid_in = 1'b0;
        check("level_one_trig", 64'(trig_cnt), 64'd1);
        check("level_note0", 64'(voice_note_out[6:0]), 64'd70);

        // All notes off
        send(4'h3, 8'd123, 8'd0);
        check("alloff_active", 64'(voice_active_out), 64'h0);
        check("alloff_gate",   64'(voice_gate_out),   64'h0);

        // Ignored status, then masked high bits still decode as note-on 72/80
        send(4'h2, 8'd60, 8'd60);
        check("ignored", 64'(voice_active_out), 64'h0);
        send(4'h9, 8'hC8, 8'hD0);
        check("mask_active", 64'(voice_active_out),    64'b0001);
        check("mask_note",   64'(voice_note_out[6:0]), 64'd72);
        check("mask_vel",    64'(voice_vel_out[6:0]),  64'd80);

        // Mid-stream reset with three voices active
        send(4'h1, 8'd74, 8'd10);
        send(4'h1, 8'd76, 8'd11);
        check("pre_rst_active", 64'(voice_active_out), 64'b0111);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check("mid_rst_active", 64'(voice_active_out), 64'h0);
        check("mid_rst_vel",    64'(voice_vel_out),    64'h0);
        send(4'h1, 8'd50, 8'd10);
        check("post_rst_active", 64'(voice_active_out), 64'b0001);
        check("post_rst_note",   64'(voice_note_out[6:0]), 64'd50);

        repeat (3) @(negedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
